// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: shares one hps_io virtual-disk channel among NUM_REQ
// block-device clients with round-robin grants. It latches each client's
// read/write requests, presents the winner's LBA and command, and routes
// sd_ack and the write data between hps_io and the granted client only.
module sd_req_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TW      = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [32*NUM_REQ-1:0]  req_lba,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [NUM_REQ-1:0]     req_wr,
  output logic [NUM_REQ-1:0]     req_ack,
  input  logic [8*NUM_REQ-1:0]   req_buff_din,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic [7:0]             sd_buff_din,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_pend_rd;
  logic [NUM_REQ-1:0]   r_pend_wr;
  logic [1:0]           r_ptr;
  logic [1:0]           r_grant;
  logic [31:0]          r_lba;
  logic                 r_sd_rd;
  logic                 r_sd_wr;
  logic                 r_busy;
  logic                 r_to_err;
  logic                 r_old_ack;
  logic                 r_is_wr;
  logic [TW-1:0]        r_cnt;

  logic [NUM_REQ-1:0]   w_pend;
  logic [NUM_REQ-1:0]   w_clr_rd;
  logic [NUM_REQ-1:0]   w_clr_wr;
  logic [1:0]           w_sel;
  logic                 w_any;
  logic                 w_ack_rise;
  logic                 w_timeout;
  int unsigned          w_idx;

  assign w_pend     = r_pend_rd | r_pend_wr;
  assign w_ack_rise = sd_ack & ~r_old_ack;

  // Command watchdog: abort when no ack rise arrives within TIMEOUT cycles.
  if (TIMEOUT != 0) begin : g_timeout
    assign w_timeout = (r_state == S_ISSUE) && !w_ack_rise &&
                       (r_cnt == TW'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  // Round-robin pick: first pending client at or after the pointer.
  always_comb begin
    w_sel = 2'd0;
    w_any = 1'b0;
    w_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_any && w_pend[w_idx]) begin
        w_sel = 2'(w_idx);
        w_any = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_ack_rise)     w_state_nxt = S_XFER;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_XFER:  if (!sd_ack) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: pending clears, ack routing and write-data mux.
  always_comb begin
    w_clr_rd    = '0;
    w_clr_wr    = '0;
    req_ack     = '0;
    sd_buff_din = 8'd0;
    if (r_state == S_ISSUE && (w_ack_rise || w_timeout)) begin
      if (r_is_wr) w_clr_wr[r_grant] = 1'b1;
      else         w_clr_rd[r_grant] = 1'b1;
    end
    // A stale ack never reaches a client; only a rise seen in ISSUE opens the window.
    if (r_state == S_XFER || (r_state == S_ISSUE && w_ack_rise))
      req_ack[r_grant] = sd_ack;
    if (r_is_wr && (r_state == S_ISSUE || r_state == S_XFER))
      sd_buff_din = req_buff_din[8*r_grant +: 8];
  end

  // Registered datapath: pending bits, grant capture, command and status flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pend_rd <= '0;
      r_pend_wr <= '0;
      r_ptr     <= 2'd0;
      r_grant   <= 2'd0;
      r_lba     <= 32'd0;
      r_sd_rd   <= 1'b0;
      r_sd_wr   <= 1'b0;
      r_busy    <= 1'b0;
      r_to_err  <= 1'b0;
      r_old_ack <= 1'b1;
      r_is_wr   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_old_ack <= sd_ack;
      r_to_err  <= 1'b0;
      // A request landing on the clear cycle survives because the OR is applied last.
      r_pend_rd <= (r_pend_rd & ~w_clr_rd) | req_rd;
      r_pend_wr <= (r_pend_wr & ~w_clr_wr) | req_wr;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_lba   <= req_lba[32*w_sel +: 32];
            r_busy  <= 1'b1;
            r_is_wr <= ~r_pend_rd[w_sel];
            r_sd_rd <= r_pend_rd[w_sel];
            r_sd_wr <= ~r_pend_rd[w_sel];
            r_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          if (w_ack_rise) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
          end else if (w_timeout) begin
            r_sd_rd  <= 1'b0;
            r_sd_wr  <= 1'b0;
            r_busy   <= 1'b0;
            r_to_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        S_XFER: begin
          if (!sd_ack) r_busy <= 1'b0;
        end
        S_DONE: begin
          r_ptr <= (32'(r_grant) == NUM_REQ - 1) ? 2'd0 : r_grant + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign sd_lba      = r_lba;
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: a transaction-level model tracks the expected
// grant/command/transfer phases for two instances (no timeout and
// TIMEOUT=16) and is compared every cycle, alongside directed checks.
module tb_sd_req_arbiter;

  logic        clk = 1'b0;
  logic        rst0, rst1, ack0, ack1;
  logic [95:0] lba;
  logic [2:0]  rd, wr;
  logic [23:0] din;

  logic [2:0]  o0_req_ack, o1_req_ack;
  logic [31:0] o0_lba, o1_lba;
  logic        o0_rd, o0_wr, o1_rd, o1_wr;
  logic [7:0]  o0_din, o1_din;
  logic [1:0]  o0_grant, o1_grant;
  logic        o0_busy, o1_busy, o0_to, o1_to;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sd_req_arbiter #(.NUM_REQ(3), .TIMEOUT(0), .TW(24)) u_dut0 (
    .clk_sys(clk), .reset(rst0), .req_lba(lba), .req_rd(rd), .req_wr(wr),
    .req_ack(o0_req_ack), .req_buff_din(din), .sd_lba(o0_lba), .sd_rd(o0_rd),
    .sd_wr(o0_wr), .sd_ack(ack0), .sd_buff_din(o0_din), .grant(o0_grant),
    .busy(o0_busy), .timeout_err(o0_to)
  );

  sd_req_arbiter #(.NUM_REQ(3), .TIMEOUT(16), .TW(24)) u_dut1 (
    .clk_sys(clk), .reset(rst1), .req_lba(lba), .req_rd(rd), .req_wr(wr),
    .req_ack(o1_req_ack), .req_buff_din(din), .sd_lba(o1_lba), .sd_rd(o1_rd),
    .sd_wr(o1_wr), .sd_ack(ack1), .sd_buff_din(o1_din), .grant(o1_grant),
    .busy(o1_busy), .timeout_err(o1_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  logic [2:0]  m_pend_rd[2], m_pend_wr[2];
  int          m_ptr[2], m_grant[2], m_waited[2];
  logic [31:0] m_lba[2];
  bit          m_busy[2], m_cmd[2], m_xfer[2], m_cool[2], m_is_wr[2], m_to[2], m_old_ack[2];
  bit          m_started = 1'b0;

  task automatic model_edge(input int u, input int tmo, input logic rst, input logic ack);
    logic [2:0] clr_rd, clr_wr, pend;
    bit prev, found;
    int i;
    prev = m_old_ack[u];
    m_old_ack[u] = ack;
    m_to[u] = 1'b0;
    clr_rd = '0;
    clr_wr = '0;
    if (rst) begin
      m_pend_rd[u] = '0; m_pend_wr[u] = '0; m_ptr[u] = 0; m_grant[u] = 0;
      m_lba[u] = '0; m_busy[u] = 0; m_cmd[u] = 0; m_xfer[u] = 0; m_cool[u] = 0;
      m_is_wr[u] = 0; m_old_ack[u] = 1'b1; m_waited[u] = 0;
      return;
    end
    if (m_cool[u]) begin
      m_cool[u] = 0;
      m_ptr[u]  = (m_grant[u] + 1) % 3;
    end else if (!m_busy[u]) begin
      pend  = m_pend_rd[u] | m_pend_wr[u];
      found = 0;
      for (int k = 0; k < 3; k++) begin
        i = (m_ptr[u] + k) % 3;
        if (!found && pend[i]) begin
          found       = 1;
          m_grant[u]  = i;
          m_lba[u]    = lba[32*i +: 32];
          m_is_wr[u]  = !m_pend_rd[u][i];
          m_busy[u]   = 1;
          m_cmd[u]    = 1;
          m_waited[u] = 0;
        end
      end
    end else if (m_cmd[u]) begin
      m_waited[u]++;
      if (ack && !prev) begin
        m_cmd[u]  = 0;
        m_xfer[u] = 1;
        if (m_is_wr[u]) clr_wr[m_grant[u]] = 1'b1; else clr_rd[m_grant[u]] = 1'b1;
      end else if (tmo != 0 && m_waited[u] == tmo) begin
        m_cmd[u]  = 0;
        m_busy[u] = 0;
        m_cool[u] = 1;
        m_to[u]   = 1;
        if (m_is_wr[u]) clr_wr[m_grant[u]] = 1'b1; else clr_rd[m_grant[u]] = 1'b1;
      end
    end else if (m_xfer[u]) begin
      if (!ack) begin
        m_xfer[u] = 0;
        m_busy[u] = 0;
        m_cool[u] = 1;
      end
    end
    m_pend_rd[u] = (m_pend_rd[u] & ~clr_rd) | rd;
    m_pend_wr[u] = (m_pend_wr[u] & ~clr_wr) | wr;
  endtask

  always @(posedge clk) begin
    model_edge(0, 0, rst0, ack0);
    model_edge(1, 16, rst1, ack1);
    m_started = 1'b1;
  end

  task automatic check_inst(input int u, input logic [2:0] a_ack, input logic [31:0] a_lba,
                            input logic a_rd, input logic a_wr, input logic [7:0] a_din,
                            input logic [1:0] a_g, input logic a_busy, input logic a_to,
                            input logic ack);
    logic [2:0] e_ack;
    logic [7:0] e_din;
    e_ack = '0;
    if (m_xfer[u]) e_ack[m_grant[u]] = ack;
    e_din = ((m_cmd[u] || m_xfer[u]) && m_is_wr[u]) ? din[8*m_grant[u] +: 8] : 8'h00;
    chk($sformatf("u%0d sd_rd", u), a_rd, m_cmd[u] && !m_is_wr[u]);
    chk($sformatf("u%0d sd_wr", u), a_wr, m_cmd[u] && m_is_wr[u]);
    chk($sformatf("u%0d busy", u), a_busy, m_busy[u]);
    chk($sformatf("u%0d grant", u), a_g, m_grant[u]);
    chk($sformatf("u%0d sd_lba", u), a_lba, m_lba[u]);
    chk($sformatf("u%0d req_ack", u), a_ack, e_ack);
    chk($sformatf("u%0d sd_buff_din", u), a_din, e_din);
    chk($sformatf("u%0d timeout_err", u), a_to, m_to[u]);
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      check_inst(0, o0_req_ack, o0_lba, o0_rd, o0_wr, o0_din, o0_grant, o0_busy, o0_to, ack0);
      check_inst(1, o1_req_ack, o1_lba, o1_rd, o1_wr, o1_din, o1_grant, o1_busy, o1_to, ack1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    step();
    step();
    rst0 = 1'b0;
  endtask

  // Wait for a command on instance 0, check it, then run a 2-cycle ack.
  task automatic serve(input int exp_g, input logic exp_wr, input logic [2:0] rereq,
                       input logic [7:0] exp_din);
    int n;
    n = 0;
    while (!(o0_rd || o0_wr) && n < 20) begin
      step();
      n++;
    end
    chk("serve cmd seen", 32'(n < 20), 32'd1);
    chk("serve grant", o0_grant, exp_g);
    chk("serve is write", o0_wr, exp_wr);
    chk("serve lba", o0_lba, lba[32*exp_g +: 32]);
    ack0 = 1'b1;
    rd   = rereq;
    step();
    rd = 3'b000;
    chk("serve req_ack", o0_req_ack, 32'd1 << exp_g);
    chk("serve din", o0_din, exp_din);
    chk("serve cmd dropped", o0_rd | o0_wr, 1'b0);
    step();
    ack0 = 1'b0;
    step();
    chk("serve busy released", o0_busy, 1'b0);
  endtask

  initial begin
    int n, cnt;
    rst0 = 1'b1; rst1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
    rd = '0; wr = '0;
    lba = {32'h0000_2222, 32'h0000_1234, 32'h0000_0AAA};
    din = 24'h33_77_A5;
    step(); step();
    chk("reset busy", o0_busy, 1'b0);
    chk("reset grant", o0_grant, 2'd0);
    chk("reset sd_lba", o0_lba, 32'd0);
    rst0 = 1'b0;

    // Single read on client 1: command two cycles after the request.
    step();
    rd = 3'b010;
    step();
    rd = 3'b000;
    chk("t1 sd_rd one cycle after req", o0_rd, 1'b0);
    step();
    chk("t1 sd_rd two cycles after req", o0_rd, 1'b1);
    chk("t1 sd_lba", o0_lba, 32'h0000_1234);
    chk("t1 grant", o0_grant, 2'd1);
    chk("t1 busy", o0_busy, 1'b1);
    ack0 = 1'b1;
    step();
    chk("t1 sd_rd dropped", o0_rd, 1'b0);
    chk("t1 req_ack", o0_req_ack, 3'b010);
    chk("t1 read din zero", o0_din, 8'h00);
    step();
    ack0 = 1'b0;
    step();
    chk("t1 busy low after ack fall", o0_busy, 1'b0);
    chk("t1 req_ack low", o0_req_ack, 3'b000);
    step(); step();

    // Simultaneous reads: served 0,1,2.
    reset0();
    rd = 3'b111;
    step();
    rd = 3'b000;
    serve(0, 1'b0, 3'b000, 8'h00);
    serve(1, 1'b0, 3'b000, 8'h00);
    serve(2, 1'b0, 3'b000, 8'h00);

    // Fairness: client 0 re-requests on its ack cycle while client 2 waits.
    reset0();
    rd = 3'b101;
    step();
    rd = 3'b000;
    serve(0, 1'b0, 3'b001, 8'h00);
    serve(2, 1'b0, 3'b000, 8'h00);
    serve(0, 1'b0, 3'b000, 8'h00);

    // Read and write on client 0: read first, write data only on the write.
    reset0();
    rd = 3'b001; wr = 3'b001;
    step();
    rd = 3'b000; wr = 3'b000;
    serve(0, 1'b0, 3'b000, 8'h00);
    serve(0, 1'b1, 3'b000, 8'hA5);
    step();
    chk("t4 din idle zero", o0_din, 8'h00);

    // Reset in the middle of a transfer, with sd_ack left high.
    reset0();
    rd = 3'b001;
    step();
    rd = 3'b000;
    n = 0;
    while (!o0_rd && n < 20) begin step(); n++; end
    chk("t5 cmd seen", 32'(n < 20), 32'd1);
    ack0 = 1'b1;
    step();
    chk("t5 req_ack before reset", o0_req_ack, 3'b001);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    chk("t5 reset req_ack", o0_req_ack, 3'b000);
    chk("t5 reset sd_rd", o0_rd, 1'b0);
    chk("t5 reset busy", o0_busy, 1'b0);
    chk("t5 reset sd_lba", o0_lba, 32'd0);
    chk("t5 reset grant", o0_grant, 2'd0);
    rd = 3'b100;
    step();
    rd = 3'b000;
    step();
    chk("t5 new sd_rd", o0_rd, 1'b1);
    chk("t5 new grant", o0_grant, 2'd2);
    step(); step();
    chk("t5 stale ack ignored", o0_req_ack, 3'b000);
    chk("t5 sd_rd held", o0_rd, 1'b1);
    ack0 = 1'b0;
    step();
    ack0 = 1'b1;
    step();
    chk("t5 fresh ack", o0_req_ack, 3'b100);
    chk("t5 sd_rd dropped", o0_rd, 1'b0);
    ack0 = 1'b0;
    step(); step();

    // Timeout instance: writes on clients 0 and 1, never acked.
    rst0 = 1'b1;
    rst1 = 1'b0;
    step();
    wr = 3'b011;
    step();
    wr = 3'b000;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (!o1_wr && n < 10) begin step(); n++; end
      chk("t6 wr seen", 32'(n < 10), 32'd1);
      chk("t6 grant", o1_grant, t);
      cnt = 0;
      while (o1_wr && cnt < 40) begin cnt++; step(); end
      chk("t6 sd_wr cycles", cnt, 16);
      chk("t6 timeout_err pulse", o1_to, 1'b1);
      chk("t6 busy dropped", o1_busy, 1'b0);
      step();
      chk("t6 timeout_err one cycle", o1_to, 1'b0);
    end
    step(); step(); step();
    chk("t6 nothing left pending", o1_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares one hps_io virtual-disk channel (one sd_lba/sd_rd/sd_wr/sd_ack set plus the common sd_buff bus) among NUM_REQ block-device clients: floppy_track 1, the HDD request logic and floppy_track 2.
- Latches client read/write requests, grants them round-robin and presents the winner's LBA and command to hps_io.
- Routes sd_ack and write data between hps_io and the granted client only.
- Drives a busy/wait flag that the top level may OR into CPU_WAIT.

Parameters:
NUM_REQ, 3, number of clients (2..4); index 0 has priority after reset.
TIMEOUT, 0, cycles to wait for sd_ack rise after a command is issued; 0 disables the timeout.
TW, 24, width of the timeout counter.

Ports:
clk_sys  in  1  system clock.
reset  in  1  synchronous, active-high reset.
req_lba  in  32*NUM_REQ  per-client LBA; client i uses bits [32i+31:32i].
req_rd  in  NUM_REQ  per-client read request, pulse or level.
req_wr  in  NUM_REQ  per-client write request, pulse or level.
req_ack  out  NUM_REQ  per-client ack; equals sd_ack on the granted bit, 0 elsewhere.
req_buff_din  in  8*NUM_REQ  per-client write data for sd_buff_din.
sd_lba  out  32  LBA to hps_io.
sd_rd  out  1  read command to hps_io.
sd_wr  out  1  write command to hps_io.
sd_ack  in  1  ack from hps_io.
sd_buff_din  out  8  req_buff_din of the granted client; 0 when no client is granted.
grant  out  2  index of the granted client.
busy  out  1  high from grant until release.
timeout_err  out  1  one-cycle pulse when a command is aborted on timeout.

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, req_ack=0, busy=0, grant=0, timeout_err=0, all pending bits=0, round-robin pointer=0, state=IDLE.
- Pending bits:
  - pend_rd[i] |= req_rd[i] and pend_wr[i] |= req_wr[i] every cycle, including while busy.
  - A request arriving in the same cycle as its clear is kept pending, not lost.
- IDLE:
  - If any client has pend_rd|pend_wr set, select the first such client starting at the pointer and wrapping modulo NUM_REQ.
  - Register grant and sd_lba (sd_lba is captured from req_lba[grant] at this moment), set busy=1, go to ISSUE.
  - Latency from the request cycle to sd_rd/sd_wr high is 2 cycles.
- ISSUE:
  - If the granted client has pend_rd set, drive sd_rd=1; otherwise drive sd_wr=1.
  - With both pending, the read is issued first; the write stays pending and is served on a later grant.
  - On the sd_ack rising edge (sd_ack=1 while the registered old_ack=0): drop sd_rd/sd_wr, clear the pending bit just served, go to XFER.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no ack: drop the command, clear that pending bit, pulse timeout_err, go to DONE.
- XFER:
  - req_ack[grant] follows sd_ack combinationally.
  - sd_buff_din = req_buff_din[grant].
  - On the sd_ack falling edge, go to DONE.
- DONE (1 cycle):
  - busy=0, pointer=grant+1 mod NUM_REQ, go to IDLE.
  - Back-to-back grants are therefore separated by at least 2 cycles.
- sd_ack high in IDLE, or already high on entry to ISSUE, is ignored. Only a rising edge observed in ISSUE counts.
- Reset mid-transfer:
  - All outputs and pending bits return to reset values on the next edge.
  - sd_ack still high after reset is ignored until it falls and rises again.
- grant and sd_lba stay stable from IDLE exit until DONE.
- Only one client is ever granted.

Test Plan:
- Single read: req_rd[1] pulse, req_lba[1]=0x1234 -> sd_rd high 2 cycles later, sd_lba=0x1234, grant=1; sd_ack 0→1 → sd_rd low next cycle, req_ack=3'b010 while ack high; ack falls → busy=0 one cycle later.
- Simultaneous requests: req_rd=3'b111 pulsed together after reset -> grants served in order 0,1,2; each LBA matches its client; busy drops for ≥1 cycle between grants.
- Round-robin fairness: client 0 re-requests immediately after each ack; client 2 is pending -> the grant after 0 is 2 (via 1 if pending), never 0,0.
- Read+write on one client: req_rd[0] and req_wr[0] high in the same cycle -> sd_rd transaction first, then sd_wr transaction; req_buff_din[0]=0xA5 appears on sd_buff_din only during the write grant, and sd_buff_din is 0 at all other times.
- Timeout: TIMEOUT=16, never ack -> sd_wr drops after 16 cycles, timeout_err pulses once, pending cleared, next client granted.
- Reset mid-XFER: reset during ack high -> all outputs 0; a new req_rd[2] with sd_ack still high is not granted an ack until sd_ack falls and rises again.
